exe_div_unit: RTL and testbench

- Iterative radix-2 restoring divider for DIV/DIVU in the EXE stage, directly upstream of the MEM stage.
- Holds the instruction in EXE via a stall while it iterates.
- Presents the quotient (LO) and remainder (HI) to the EXE/MEM pipeline register when done.
- Is cancelled by the exception flush that MEM raises.

---
 rtl/div_pkg.sv | 18 +
 rtl/exe_div_unit_if.sv | 28 ++
 rtl/div_lzc.sv | 20 ++
 rtl/exe_div_unit.sv | 140 ++++++++++++++
 tb/tb_exe_div_unit.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the EXE-stage divider
// Purpose: FSM state encoding, default width and divide-by-zero result constants.
// Ports: none (package).
package div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } DivState;

  localparam int DIV_DEFAULT_W = 32;

  // A zero divisor yields an all-ones quotient; the remainder is the dividend.
  localparam logic                     DIV_DBZ_Q_BIT    = 1'b1;
  localparam logic [DIV_DEFAULT_W-1:0] DIV_DBZ_QUOTIENT = '1;

endpackage

// File: rtl/exe_div_unit_if.sv
// rtl/exe_div_unit_if.sv - EXE pipeline <-> divider handshake bundle
// Purpose: groups request, control and result signals of the divider.
// Ports (master = pipeline side, slave = divider side):
//   start, is_signed, dividend, divisor, cancel, exe_wr : master -> slave
//   div_stall, done, quotient, remainder, div_by_zero   : slave -> master
interface exe_div_unit_if #(parameter int DATA_W = 32);
  logic              start;
  logic              is_signed;
  logic [DATA_W-1:0] dividend;
  logic [DATA_W-1:0] divisor;
  logic              cancel;
  logic              exe_wr;
  logic              div_stall;
  logic              done;
  logic [DATA_W-1:0] quotient;
  logic [DATA_W-1:0] remainder;
  logic              div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor, cancel, exe_wr,
    input  div_stall, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor, cancel, exe_wr,
    output div_stall, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_lzc.sv
// rtl/div_lzc.sv - parameterised leading-zero counter
// Purpose: counts leading zeros of value; an all-zero input returns DATA_W.
// Ports: value (in, DATA_W), lz (out, CNT_W).
module div_lzc #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic [DATA_W-1:0] value,
  output logic [CNT_W-1:0]  lz
);

  // Scan upward; the highest set bit is the last to overwrite lz.
  always_comb begin
    lz = CNT_W'(DATA_W);
    for (int i = 0; i < DATA_W; i++) begin
      if (value[i]) lz = CNT_W'(DATA_W - 1 - i);
    end
  end

endmodule

// File: rtl/exe_div_unit.sv
// rtl/exe_div_unit.sv - iterative radix-2 restoring divider for DIV/DIVU in EXE
// Purpose: stalls EXE while iterating, presents quotient (LO) / remainder (HI)
//   with done, cancelled by the MEM exception flush.
// Ports: clk, rst (sync, active-high), bus (exe_div_unit_if.slave).
// Optional: DIV_EARLY_OUT_EN skips leading-zero iterations and finishes
//   zero-dividend / zero-divisor cases on the cycle after accept.
module exe_div_unit
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_DEFAULT_W,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input logic           clk,
  input logic           rst,
  exe_div_unit_if.slave bus
);

  DivState           state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] pr;     // partial remainder
  logic [DATA_W-1:0] dq;     // dividend bits shift out the top, quotient bits in the bottom
  logic [DATA_W-1:0] dsr;    // divisor magnitude
  logic [DATA_W-1:0] q_r;
  logic [DATA_W-1:0] r_r;
  logic              neg_q;
  logic              neg_r;
  logic              dbz;
  logic              done_r;

  logic              dvd_neg;
  logic              dsr_neg;
  logic [DATA_W-1:0] dvd_mag;
  logic [DATA_W-1:0] dsr_mag;

  assign dvd_neg = bus.is_signed & bus.dividend[DATA_W-1];
  assign dsr_neg = bus.is_signed & bus.divisor[DATA_W-1];
  assign dvd_mag = dvd_neg ? -bus.dividend : bus.dividend;
  assign dsr_mag = dsr_neg ? -bus.divisor  : bus.divisor;

  logic [CNT_W-1:0]  cnt_init;
  logic [DATA_W-1:0] dq_init;
  logic              skip;

`ifdef DIV_EARLY_OUT_EN
  logic [CNT_W-1:0] lz;

  div_lzc #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_lzc (
    .value (dvd_mag),
    .lz    (lz)
  );

  // Leading zeros only ever produce zero quotient bits, so pre-shift them away.
  assign cnt_init = CNT_W'(DATA_W) - lz;
  assign dq_init  = dvd_mag << lz;
  assign skip     = (dvd_mag == '0) || (dsr_mag == '0);
`else
  assign cnt_init = CNT_W'(DATA_W);
  assign dq_init  = dvd_mag;
  assign skip     = 1'b0;
`endif

  // One restoring step. pr < dsr holds for any nonzero divisor, so the
  // (DATA_W+1)-bit difference's MSB is a reliable sign bit.
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] pr_next;
  logic [DATA_W-1:0] q_next;

  assign shifted = {pr, dq[DATA_W-1]};
  assign diff    = shifted - {1'b0, dsr};
  assign pr_next = diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
  assign q_next  = {dq[DATA_W-2:0], ~diff[DATA_W]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= DIV_IDLE;
      cnt    <= '0;
      pr     <= '0;
      dq     <= '0;
      dsr    <= '0;
      q_r    <= '0;
      r_r    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dbz    <= 1'b0;
      done_r <= 1'b0;
    end else if (bus.cancel) begin
      state  <= DIV_IDLE;
      done_r <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (bus.start) begin
            dbz   <= (dsr_mag == '0);
            neg_q <= dvd_neg ^ dsr_neg;
            neg_r <= dvd_neg;
            pr    <= '0;
            dq    <= dq_init;
            dsr   <= dsr_mag;
            cnt   <= cnt_init;
            if (skip) begin
              // Only reachable with a zero dividend or divisor.
              state  <= DIV_DONE;
              done_r <= 1'b1;
              q_r    <= (dsr_mag == '0) ? {DATA_W{DIV_DBZ_Q_BIT}} : '0;
              r_r    <= bus.dividend;
            end else begin
              state <= DIV_BUSY;
            end
          end
        end
        DIV_BUSY: begin
          pr  <= pr_next;
          dq  <= q_next;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state  <= DIV_DONE;
            done_r <= 1'b1;
            q_r    <= dbz ? {DATA_W{DIV_DBZ_Q_BIT}} : (neg_q ? -q_next : q_next);
            r_r    <= neg_r ? -pr_next : pr_next;
          end
        end
        DIV_DONE: begin
          if (bus.exe_wr) begin
            state  <= DIV_IDLE;
            done_r <= 1'b0;
          end
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

  assign bus.div_stall   = (state == DIV_IDLE && bus.start && !bus.cancel) || (state == DIV_BUSY);
  assign bus.done        = done_r & ~bus.cancel;
  assign bus.quotient    = q_r;
  assign bus.remainder   = r_r;
  assign bus.div_by_zero = dbz;

endmodule

// File: tb/tb_exe_div_unit.sv
// tb/tb_exe_div_unit.sv - self-checking scoreboard bench for exe_div_unit
module tb_exe_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exe_div_unit_if #(.DATA_W(32)) bus ();

  exe_div_unit #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } res_t;

  res_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input bit s, input logic [31:0] a, input logic [31:0] b);
    res_t res;
    int sa, sb_;
    res.dbz = (b == 32'd0);
    if (b == 32'd0) begin
      res.q = 32'hFFFF_FFFF;
      res.r = a;
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        res.q = 32'h8000_0000;
        res.r = 32'd0;
      end else begin
        sa = $signed(a);
        sb_ = $signed(b);
        res.q = 32'(sa / sb_);
        res.r = 32'(sa % sb_);
      end
    end else begin
      res.q = a / b;
      res.r = a % b;
    end
    return res;
  endfunction

  function automatic int exp_latency(input bit s, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    logic [31:0] mag;
    int lz;
    mag = (s && a[31]) ? -a : a;
    if (mag == 32'd0 || b == 32'd0) return 1;
    lz = 32;
    for (int i = 0; i < 32; i++) if (mag[i]) lz = 31 - i;
    return 1 + 32 - lz;
`else
    return 33;
`endif
  endfunction

  // Drives one divide, checks stall length and latency, pops and compares the
  // scoreboard entry, optionally holds exe_wr low in DONE for 'hold' cycles.
  task automatic do_div(input bit s, input logic [31:0] a, input logic [31:0] b, input int hold);
    int   lat;
    int   stall_cnt;
    int   exp_lat;
    res_t e;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_signed = s;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.exe_wr    = (hold == 0);
    sb.push_back(model(s, a, b));
    exp_lat = exp_latency(s, a, b);
    #1;
    check("stall_accept", bus.div_stall, 1'b1);
    lat = 0;
    stall_cnt = 1;
    while (!bus.done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (!bus.done && bus.div_stall) stall_cnt++;
    end
    if (!bus.done) begin
      check("done_timeout", 1'b0, 1'b1);
      sb.delete();
      return;
    end
    check("latency", lat, exp_lat);
    check("stall_cycles", stall_cnt, exp_lat);
    check("stall_in_done", bus.div_stall, 1'b0);
    e = sb.pop_front();
    check("quotient", bus.quotient, e.q);
    check("remainder", bus.remainder, e.r);
    check("div_by_zero", bus.div_by_zero, e.dbz);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_done", bus.done, 1'b1);
      check("hold_quotient", bus.quotient, e.q);
      check("hold_remainder", bus.remainder, e.r);
      check("hold_stall", bus.div_stall, 1'b0);
    end
    bus.exe_wr = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    check("idle_done", bus.done, 1'b0);
    check("idle_stall", bus.div_stall, 1'b0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.cancel    = 1'b0;
    bus.exe_wr    = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_done", bus.done, 1'b0);
    check("rst_quotient", bus.quotient, 32'd0);
    check("rst_remainder", bus.remainder, 32'd0);
    check("rst_dbz", bus.div_by_zero, 1'b0);
    check("rst_stall", bus.div_stall, 1'b0);

    do_div(1'b0, 32'd100, 32'd7, 0);
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_div(1'b0, 32'd5, 32'd0, 0);
    do_div(1'b1, 32'hFFFF_FFF7, 32'd0, 0);
    do_div(1'b0, 32'd0, 32'd9, 0);
    do_div(1'b0, 32'd1234567, 32'd89, 4);
    do_div(1'b0, 32'h0000_00FF, 32'd3, 0);

    // Cancel ten cycles into the iteration.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_signed = 1'b0;
    bus.dividend  = 32'd1000;
    bus.divisor   = 32'd3;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("cancel_no_done", bus.done, 1'b0);
    end
    bus.cancel = 1'b1;
    bus.start  = 1'b0;
    #1;
    check("cancel_done_same", bus.done, 1'b0);
    @(negedge clk);
    bus.cancel = 1'b0;
    #1;
    check("cancel_done_next", bus.done, 1'b0);
    check("cancel_stall", bus.div_stall, 1'b0);
    do_div(1'b0, 32'd1000, 32'd3, 0);

    // Reset in the middle of an iteration.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_signed = 1'b1;
    bus.dividend  = 32'hFFFF_FF00;
    bus.divisor   = 32'd7;
    repeat (5) @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_done", bus.done, 1'b0);
    check("midrst_quotient", bus.quotient, 32'd0);
    check("midrst_remainder", bus.remainder, 32'd0);
    check("midrst_dbz", bus.div_by_zero, 1'b0);
    check("midrst_stall", bus.div_stall, 1'b0);

    for (int i = 0; i < 6; i++) begin
      do_div(1'($urandom_range(0, 1)), $urandom, $urandom >> $urandom_range(0, 31), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
